softmax_job_scheduler: RTL and testbench



---
 rtl/softmax_job_scheduler_if.sv | 29 ++
 rtl/softmax_job_scheduler.sv | 153 +++++++++++++++
 tb/tb_softmax_job_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_job_scheduler_if.sv
// Job request/response port of the softmax job scheduler: per-requester
// request vectors in, one tagged result out under ready/valid.
interface softmax_job_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int IN_OUT_NUM = 10
);
    localparam int VEC_W = IN_OUT_NUM * 16;
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*VEC_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_err;
    logic [VEC_W-1:0]         rsp_data;

    // master: the requesters plus the response consumer
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_err, rsp_data
    );
endinterface

// File: rtl/softmax_job_scheduler.sv
// Round-robin scheduler sharing one fp16_softmax engine among NUM_REQ
// requesters, with a watchdog that aborts a hung engine job.
module softmax_job_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int IN_OUT_NUM  = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    softmax_job_scheduler_if.slave   job,
    output logic                     sm_start_op,
    output logic                     sm_clear,
    output logic [IN_OUT_NUM*16-1:0] sm_input,
    input  logic [IN_OUT_NUM*16-1:0] sm_output,
    input  logic                     sm_valid
);

    localparam int VEC_W = IN_OUT_NUM * 16;
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [TMR_W-1:0] timer;
    logic [VEC_W-1:0] in_buf;
    logic [VEC_W-1:0] out_buf;
    logic [ID_W-1:0]  id_buf;
    logic             err_buf;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  scan_idx;
    logic             timeout_hit;

    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYC - 1));

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && job.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (grant_found) state_nxt = S_LAUNCH;
                S_LAUNCH: state_nxt = S_WAIT;
                S_WAIT:   if (sm_valid || timeout_hit) state_nxt = S_RESP;
                S_RESP:   if (job.rsp_ready) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        job.req_ready = '0;
        job.rsp_valid = 1'b0;
        sm_start_op   = 1'b0;
        sm_clear      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!clear && grant_found) job.req_ready[grant_idx] = 1'b1;
            end
            S_LAUNCH: begin
                if (clear) sm_clear    = 1'b1;
                else       sm_start_op = 1'b1;
            end
            S_WAIT: begin
                // A completion in the timeout cycle wins over the watchdog.
                if (clear || (!sm_valid && timeout_hit)) sm_clear = 1'b1;
            end
            S_RESP: begin
                job.rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the vector buffers are reset too, so the engine and the response
    // port never expose X before the first job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            timer   <= '0;
            in_buf  <= '0;
            out_buf <= '0;
            id_buf  <= '0;
            err_buf <= 1'b0;
        end else if (clear) begin
            rr_ptr <= '0;
            timer  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        in_buf <= job.req_data[grant_idx * VEC_W +: VEC_W];
                        id_buf <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                    : grant_idx + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (sm_valid) begin
                        out_buf <= sm_output;
                        err_buf <= 1'b0;
                    end else if (timeout_hit) begin
                        out_buf <= '0;
                        err_buf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sm_input     = in_buf;
    assign job.rsp_id   = id_buf;
    assign job.rsp_err  = err_buf;
    assign job.rsp_data = out_buf;

endmodule

// File: tb/tb_softmax_job_scheduler.sv
// Directed bench: instance A (long watchdog) covers grant, round-robin,
// backpressure and clear; instance B (TIMEOUT_CYC=16) covers the watchdog.
module tb_softmax_job_scheduler;

    localparam int NR = 4;
    localparam int N  = 10;
    localparam int VW = N * 16;

    typedef struct packed {
        logic [1:0]    id;
        logic          err;
        logic [VW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    logic clear_a, clear_b;

    logic          sm_start_a, sm_clear_a, sm_valid_a;
    logic [VW-1:0] sm_input_a, sm_output_a;
    logic          sm_start_b, sm_clear_b, sm_valid_b;
    logic [VW-1:0] sm_input_b, sm_output_b;

    softmax_job_scheduler_if #(.NUM_REQ(NR), .IN_OUT_NUM(N)) ja ();
    softmax_job_scheduler_if #(.NUM_REQ(NR), .IN_OUT_NUM(N)) jb ();

    softmax_job_scheduler #(.NUM_REQ(NR), .IN_OUT_NUM(N), .TIMEOUT_CYC(64)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear_a),
        .job         (ja),
        .sm_start_op (sm_start_a),
        .sm_clear    (sm_clear_a),
        .sm_input    (sm_input_a),
        .sm_output   (sm_output_a),
        .sm_valid    (sm_valid_a)
    );

    softmax_job_scheduler #(.NUM_REQ(NR), .IN_OUT_NUM(N), .TIMEOUT_CYC(16)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear_b),
        .job         (jb),
        .sm_start_op (sm_start_b),
        .sm_clear    (sm_clear_b),
        .sm_input    (sm_input_b),
        .sm_output   (sm_output_b),
        .sm_valid    (sm_valid_b)
    );

    always #5 clk = ~clk;

    int            n_pass  = 0;
    int            n_total = 0;
    int            model_rr = 0;
    logic [VW-1:0] vec [NR];
    rsp_t          sb [$];

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int exp_grant(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic wait_grant_a(output int g, output int cyc);
        cyc = 0;
        g   = 0;
        #1;
        while (ja.req_ready == '0 && cyc < 50) begin
            tick();
            #1;
            cyc++;
        end
        check("grant_seen", 1'(ja.req_ready != '0), 1'b1);
        check("grant_onehot", 1'($onehot(ja.req_ready)), 1'b1);
        for (int i = 0; i < NR; i++) if (ja.req_ready[i]) g = i;
    endtask

    // Launch cycle follows the grant; the engine answers lat cycles after start.
    task automatic engine_a(input int g, input int lat, input logic [VW-1:0] res, input bit drop);
        rsp_t e;
        tick();
        if (drop) ja.req_valid[g] = 1'b0;
        #1;
        check("start_op", sm_start_a, 1'b1);
        check("ready_one_cycle", ja.req_ready, '0);
        check("sm_input", sm_input_a, vec[g]);
        for (int i = 1; i < lat; i++) begin
            tick();
            if (i == 1) begin
                #1;
                check("start_op_once", sm_start_a, 1'b0);
            end
        end
        tick();
        sm_valid_a  = 1'b1;
        sm_output_a = res;
        e.id   = 2'(g);
        e.err  = 1'b0;
        e.data = res;
        sb.push_back(e);
        tick();
        sm_valid_a  = 1'b0;
        sm_output_a = rand_vec();
    endtask

    task automatic resp_a(input int hold);
        rsp_t item;
        int   cyc = 0;
        item = '0;
        #1;
        while (!ja.rsp_valid && cyc < 10) begin
            tick();
            #1;
            cyc++;
        end
        check("rsp_valid", ja.rsp_valid, 1'b1);
        if (sb.size() > 0) item = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            // a stray engine pulse during RESP must not disturb the result
            sm_valid_a = (i == 5);
            if (i == 5) sm_output_a = ~item.data;
            check("bp_valid", ja.rsp_valid, 1'b1);
            check("bp_data", ja.rsp_data, item.data);
            check("bp_no_grant", ja.req_ready, '0);
            tick();
            #1;
        end
        sm_valid_a = 1'b0;
        check("rsp_id", ja.rsp_id, item.id);
        check("rsp_err", ja.rsp_err, item.err);
        check("rsp_data", ja.rsp_data, item.data);
        ja.rsp_ready = 1'b1;
        #1;
        check("no_grant_in_handshake", ja.req_ready, '0);
        tick();
        ja.rsp_ready = 1'b0;
        #1;
        check("rsp_dropped", ja.rsp_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int g, cyc, clr_cnt, clr_at;
        logic [VW-1:0] y;

        reset        = 1'b1;
        clear_a      = 1'b0;
        clear_b      = 1'b0;
        sm_valid_a   = 1'b0;
        sm_valid_b   = 1'b0;
        sm_output_a  = '0;
        sm_output_b  = '0;
        for (int i = 0; i < NR; i++) vec[i] = rand_vec();
        ja.req_valid = '0;
        ja.req_data  = {vec[3], vec[2], vec[1], vec[0]};
        ja.rsp_ready = 1'b0;
        jb.req_valid = '0;
        jb.req_data  = {vec[3], vec[2], vec[1], vec[0]};
        jb.rsp_ready = 1'b0;

        tick();
        tick();
        #1;
        check("rst_req_ready", ja.req_ready, '0);
        check("rst_rsp_valid", ja.rsp_valid, 1'b0);
        check("rst_rsp_err", ja.rsp_err, 1'b0);
        check("rst_rsp_id", ja.rsp_id, '0);
        check("rst_rsp_data", ja.rsp_data, '0);
        check("rst_start", sm_start_a, 1'b0);
        check("rst_clear", sm_clear_a, 1'b0);
        check("rst_sm_input", sm_input_a, '0);
        reset = 1'b0;
        tick();

        // single job from requester 1, engine latency 40
        ja.req_valid = 4'b0010;
        wait_grant_a(g, cyc);
        check("single_ready", ja.req_ready, 4'b0010);
        check("single_grant", g, exp_grant(4'b0010, model_rr));
        model_rr = (g + 1) % NR;
        engine_a(g, 40, rand_vec(), 1'b1);
        resp_a(0);

        // clear in IDLE suppresses the grant and rewinds the pointer
        ja.req_valid = 4'hF;
        clear_a = 1'b1;
        #1;
        check("clear_blocks_grant", ja.req_ready, '0);
        tick();
        clear_a  = 1'b0;
        model_rr = 0;

        // round-robin with all requesters held high
        for (int j = 0; j < 5; j++) begin
            wait_grant_a(g, cyc);
            check("rr_model", g, exp_grant(4'hF, model_rr));
            check("rr_order", g, j % NR);
            if (j > 0) check("rr_no_gap", cyc, 0);
            model_rr = (g + 1) % NR;
            engine_a(g, 3 + j, rand_vec(), 1'b0);
            resp_a(0);
        end

        // response backpressure for 20 cycles
        wait_grant_a(g, cyc);
        check("bp_grant", g, exp_grant(4'hF, model_rr));
        model_rr = (g + 1) % NR;
        engine_a(g, 5, rand_vec(), 1'b0);
        resp_a(20);

        // clear while the engine is busy
        wait_grant_a(g, cyc);
        check("cw_grant", g, exp_grant(4'hF, model_rr));
        check("cw_no_gap", cyc, 0);
        tick();
        #1;
        check("cw_start", sm_start_a, 1'b1);
        tick();
        tick();
        tick();
        clear_a = 1'b1;
        #1;
        check("cw_sm_clear", sm_clear_a, 1'b1);
        check("cw_no_start", sm_start_a, 1'b0);
        tick();
        clear_a = 1'b0;
        #1;
        check("cw_no_rsp", ja.rsp_valid, 1'b0);
        check("cw_regrant_0", ja.req_ready, 4'b0001);
        model_rr = 0;
        wait_grant_a(g, cyc);
        check("cw_grant0", g, exp_grant(4'hF, model_rr));
        model_rr = (g + 1) % NR;
        engine_a(g, 2, rand_vec(), 1'b0);
        ja.req_valid = '0;
        resp_a(0);
        check("sb_drained", sb.size(), 0);

        // watchdog: engine never answers
        jb.req_valid = 4'b0100;
        sm_output_b  = rand_vec();
        #1;
        check("to_grant", jb.req_ready, 4'b0100);
        tick();
        jb.req_valid = '0;
        #1;
        check("to_start", sm_start_b, 1'b1);
        clr_cnt = 0;
        clr_at  = 0;
        for (int w = 1; w <= 16; w++) begin
            tick();
            #1;
            if (sm_clear_b) begin
                clr_cnt++;
                clr_at = w;
            end
        end
        check("to_clear_count", clr_cnt, 1);
        check("to_clear_cycle", clr_at, 16);
        tick();
        #1;
        check("to_rsp_valid", jb.rsp_valid, 1'b1);
        check("to_rsp_err", jb.rsp_err, 1'b1);
        check("to_rsp_data", jb.rsp_data, '0);
        check("to_rsp_id", jb.rsp_id, 2'd2);
        check("to_sm_clear_gone", sm_clear_b, 1'b0);
        jb.rsp_ready = 1'b1;
        tick();
        jb.rsp_ready = 1'b0;

        // watchdog tie: completion in the 16th WAIT cycle wins
        jb.req_valid = 4'b0001;
        #1;
        check("tie_grant", jb.req_ready, 4'b0001);
        tick();
        jb.req_valid = '0;
        #1;
        check("tie_start", sm_start_b, 1'b1);
        y       = rand_vec();
        clr_cnt = 0;
        for (int w = 1; w <= 16; w++) begin
            tick();
            if (w == 16) begin
                sm_valid_b  = 1'b1;
                sm_output_b = y;
            end
            #1;
            if (sm_clear_b) clr_cnt++;
        end
        tick();
        sm_valid_b  = 1'b0;
        sm_output_b = rand_vec();
        #1;
        check("tie_no_clear", clr_cnt, 0);
        check("tie_rsp_valid", jb.rsp_valid, 1'b1);
        check("tie_rsp_err", jb.rsp_err, 1'b0);
        check("tie_rsp_data", jb.rsp_data, y);
        check("tie_rsp_id", jb.rsp_id, 2'd0);
        jb.rsp_ready = 1'b1;
        tick();
        jb.rsp_ready = 1'b0;

        // asynchronous reset in the middle of a job
        jb.req_valid = 4'b0010;
        tick();
        jb.req_valid = '0;
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;
        check("ar_sm_clear", sm_clear_b, 1'b0);
        check("ar_sm_input", sm_input_b, '0);
        check("ar_rsp_valid", jb.rsp_valid, 1'b0);
        check("ar_start", sm_start_b, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        #1;
        check("ar_idle_no_rsp", jb.rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
